// File: rtl/instr_fetch_ir.sv
// Instruction fetch stage: req/ack read from instruction memory into the IR,
// PC advance or redirect, and abort of fetches that are never acknowledged.
module instr_fetch_ir #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [15:0] pc_in,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [7:0]  imm8,
    output logic [15:0] pc_out,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] pc;
    logic [7:0]  cnt;
    logic [15:0] pend_pc;
    logic        pend_vld;
    logic        timeout_hit;
    logic        redirect;
    logic [15:0] redirect_pc;

    assign timeout_hit = (cnt == CNT_LAST);

    // A redirect arriving on the very cycle the fetch ends is the latest one.
    assign redirect    = pc_we | pend_vld;
    assign redirect_pc = pc_we ? pc_in : pend_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (fetch_start) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= 16'h0000;
            mem_req   <= 1'b0;
            mem_addr  <= 16'h0000;
            ir_valid  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
            cnt       <= 8'd0;
            pend_pc   <= 16'h0000;
            pend_vld  <= 1'b0;
        end else begin
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pc_we) begin
                        pc <= pc_in;
                    end
                    if (fetch_start) begin
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= 8'd0;
                        mem_addr <= pc_we ? pc_in : pc;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        ir_valid <= 1'b1;
                        pc       <= redirect ? redirect_pc : pc + 16'd1;
                        pend_vld <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                        if (redirect) begin
                            pc <= redirect_pc;
                        end
                        pend_vld <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (pc_we) begin
                            pend_pc  <= pc_in;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode = ir[15:12];
    assign rd     = ir[11:8];
    assign rs     = ir[7:4];
    assign imm8   = ir[7:0];
    assign pc_out = pc;

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed bench for instr_fetch_ir: normal, delayed and missing acks,
// redirects, PC wrap and asynchronous reset mid-fetch.
module tb_instr_fetch_ir;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic        pc_we;
    logic [15:0] pc_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm8;
    logic [15:0] pc_out;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_ir #(
        .RESET_PC(16'h0000),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .pc_we      (pc_we),
        .pc_in      (pc_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .imm8       (imm8),
        .pc_out     (pc_out),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic redir, input logic [15:0] target);
        fetch_start = 1'b1;
        pc_we       = redir;
        pc_in       = target;
        step();
        fetch_start = 1'b0;
        pc_we       = 1'b0;
    endtask

    task automatic ack(input logic [15:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        int n;
        int req_drop;
        int pulses;

        rst         = 1'b1;
        fetch_start = 1'b0;
        pc_we       = 1'b0;
        pc_in       = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {ir_valid, fetch_err}, 2'b00);

        // Zero-wait fetch
        start(1'b0, 16'h0000);
        chk("s1_req", mem_req, 1'b1);
        chk("s1_addr", mem_addr, 16'h0000);
        chk("s1_busy", busy, 1'b1);
        ack(16'hA35C);
        chk("s1_ir", ir, 16'hA35C);
        chk("s1_opcode", opcode, 4'hA);
        chk("s1_rd", rd, 4'h3);
        chk("s1_rs", rs, 4'h5);
        chk("s1_imm8", imm8, 8'h5C);
        chk("s1_pc", pc_out, 16'h0001);
        chk("s1_valid", ir_valid, 1'b1);
        chk("s1_done", {busy, mem_req}, 2'b00);
        step();
        chk("s1_valid_drop", ir_valid, 1'b0);

        // Ack arriving in IDLE must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_ir", ir, 16'hA35C);
        chk("idle_ack_valid", ir_valid, 1'b0);

        // Five wait states
        start(1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_hold", {mem_req, busy, mem_addr}, {2'b11, 16'h0001});
        end
        ack(16'hB7E1);
        chk("s2_ir", ir, 16'hB7E1);
        chk("s2_pc", pc_out, 16'h0002);
        chk("s2_valid", ir_valid, 1'b1);

        // Never acknowledged: timeout
        start(1'b0, 16'h0000);
        n        = 0;
        req_drop = 0;
        while (!fetch_err && n < 40) begin
            step();
            n++;
            if (!fetch_err && !mem_req) req_drop++;
        end
        chk("s3_err_seen", fetch_err, 1'b1);
        chk("s3_err_cycle", n, 16);
        chk("s3_req_held", req_drop, 0);
        chk("s3_ir", ir, 16'hB7E1);
        chk("s3_pc", pc_out, 16'h0002);
        chk("s3_idle", {busy, mem_req, ir_valid}, 3'b000);
        step();
        chk("s3_err_drop", fetch_err, 1'b0);
        start(1'b0, 16'h0000);
        chk("s3_restart", {busy, mem_addr}, {1'b1, 16'h0002});
        ack(16'h0F0F);
        chk("s3_restart_pc", pc_out, 16'h0003);

        // Redirect while waiting
        start(1'b0, 16'h0000);
        pc_we = 1'b1;
        pc_in = 16'h0040;
        step();
        pc_we = 1'b0;
        chk("s4_pc_hold", pc_out, 16'h0003);
        chk("s4_addr", mem_addr, 16'h0003);
        ack(16'h2468);
        chk("s4_ir", ir, 16'h2468);
        chk("s4_pc", pc_out, 16'h0040);
        start(1'b0, 16'h0000);
        chk("s4_next_addr", mem_addr, 16'h0040);
        ack(16'h1111);
        chk("s4_next_pc", pc_out, 16'h0041);

        // Redirect together with fetch_start
        start(1'b1, 16'h1234);
        chk("s5_addr", mem_addr, 16'h1234);
        ack(16'h5A5A);
        chk("s5_pc", pc_out, 16'h1235);

        // PC wrap
        pc_we = 1'b1;
        pc_in = 16'hFFFF;
        step();
        pc_we = 1'b0;
        chk("s6_pc_set", pc_out, 16'hFFFF);
        start(1'b0, 16'h0000);
        chk("s6_addr", mem_addr, 16'hFFFF);
        ack(16'hC3A5);
        chk("s6_pc_wrap", pc_out, 16'h0000);
        chk("s6_fields", {opcode, rd, rs, imm8}, {4'hC, 4'h3, 4'hA, 8'hA5});

        // Asynchronous reset in the middle of a fetch
        start(1'b1, 16'h0100);
        chk("s7_req", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("s7_req_drop", mem_req, 1'b0);
        chk("s7_pc", pc_out, 16'h0000);
        chk("s7_busy", busy, 1'b0);
        pulses = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ir_valid || fetch_err) pulses++;
            step();
        end
        chk("s7_no_pulses", pulses, 0);
        chk("s7_ir", ir, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
